// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_target
//  Purpose  : I2C target (slave) responder. Answers one 7-bit bus address and
//             exposes a byte-wide register window to local logic. A write sets
//             the register pointer and optionally writes data bytes; a read
//             (usually after a repeated START) streams bytes from the pointer
//             with auto-increment on every ACKed byte.
//  Ports    : clk        system clock, at least 8x the SCL rate
//             reset      synchronous, active-high reset
//             scl        bus clock from the master (asynchronous to clk)
//             sda        open-drain data line (driven low or released)
//             reg_addr   current register pointer
//             reg_rdata  local read data for reg_addr
//             reg_wdata  byte received in the data phase
//             reg_we     one-clk write strobe for reg_addr/reg_wdata
//             busy       high from an addressed START to the following STOP
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h48,
    parameter logic [7:0] PTR_RESET   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_rdata,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK      = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning. The synchronizers are deliberately not reset so
    // that they keep tracking the live bus through a reset and no false
    // START/STOP is seen when reset is released mid-transfer.
    // ------------------------------------------------------------------
    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_hist;
    logic       r_sda_hist;

    always_ff @(posedge clk) begin
        r_scl_sync <= {r_scl_sync[0], scl};
        r_sda_sync <= {r_sda_sync[0], sda};
        r_scl_hist <= r_scl_sync[1];
        r_sda_hist <= r_sda_sync[1];
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise =  w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl &  r_scl_hist;
    // SCL must be high on both samples so an SDA change racing an SCL edge
    // is not mistaken for a bus condition.
    assign w_start    = w_scl & r_scl_hist &  r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist &  w_sda;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t     r_state,     w_state_nxt;
    logic [3:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0] r_shift,     w_shift_nxt;
    logic       r_sda_oe,    w_sda_oe_nxt;
    logic [7:0] r_reg_addr,  w_reg_addr_nxt;
    logic [7:0] r_reg_wdata, w_reg_wdata_nxt;
    logic       r_reg_we,    w_reg_we_nxt;
    logic       r_busy,      w_busy_nxt;

    // Byte completed by the bit arriving on the current rising edge.
    logic [7:0] w_byte;
    assign w_byte = {r_shift[6:0], w_sda};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= PTR_RESET;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_reg_we    <= w_reg_we_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. sda_oe is only ever updated on a detected SCL
    // falling edge (or released by a bus condition), so the registered
    // output moves one clk after the edge is seen, while SCL is low.
    // In the ACK states and RACK the bit counter is reused as a phase flag:
    // 0 = before the 9th rising edge, 1 = after it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_sda_oe_nxt    = r_sda_oe;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_we_nxt    = 1'b0;
        w_busy_nxt      = r_busy;

        // Pointer advances the clk after the write strobe, so the strobe
        // always carries the address the byte was written to.
        if (r_reg_we) begin
            w_reg_addr_nxt = r_reg_addr + 8'd1;
        end

        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            if (r_state == S_ADDR) begin
                                if (w_byte[7:1] == TARGET_ADDR) begin
                                    w_state_nxt = S_ADDR_ACK;
                                    w_busy_nxt  = 1'b1;
                                end else begin
                                    w_state_nxt = S_IGNORE;
                                    w_busy_nxt  = 1'b0;
                                end
                            end else if (r_state == S_PTR) begin
                                w_reg_addr_nxt = w_byte;
                                w_state_nxt    = S_PTR_ACK;
                            end else begin
                                w_reg_wdata_nxt = w_byte;
                                w_reg_we_nxt    = 1'b1;
                                w_state_nxt     = S_WDATA_ACK;
                            end
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = 4'd0;
                            // r_shift still holds the address byte here, so
                            // bit 0 is the R/W flag.
                            if ((r_state == S_ADDR_ACK) && r_shift[0]) begin
                                w_shift_nxt  = {reg_rdata[6:0], 1'b0};
                                w_sda_oe_nxt = ~reg_rdata[7];
                                w_state_nxt  = S_RDATA;
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                            end
                        end
                    end
                end

                // r_shift[7] is always the next bit to put on the line.
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = S_RACK;
                        end else begin
                            w_sda_oe_nxt = ~r_shift[7];
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                        end
                    end
                end

                // The pointer moves on the ACK rising edge; reg_rdata for the
                // new pointer is then picked up on the following falling edge.
                S_RACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_nxt = S_IGNORE;
                        end else begin
                            w_reg_addr_nxt = r_reg_addr + 8'd1;
                            w_bit_cnt_nxt  = 4'd1;
                        end
                    end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                        w_shift_nxt   = {reg_rdata[6:0], 1'b0};
                        w_sda_oe_nxt  = ~reg_rdata[7];
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_RDATA;
                    end
                end

                default: begin
                    // S_IDLE and S_IGNORE only leave on a bus condition.
                end
            endcase
        end
    end

    assign sda       = r_sda_oe ? 1'b0 : 1'bz;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target
//  Purpose  : Self-checking bench for i2c_target. A bit-banged bus master
//             drives directed and randomized transactions; a register-file
//             model predicts acknowledges, read bytes, write strobes and the
//             final pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

    localparam int         C_Q         = 6;       // clks per quarter SCL period
    localparam logic [6:0] C_ADDR      = 7'h48;
    localparam logic [7:0] C_PTR_RESET = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda_low;
    wire        sda_line;
    logic [7:0] reg_addr;
    logic [7:0] reg_rdata;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       busy;

    pullup (sda_line);
    assign sda_line = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(
        .TARGET_ADDR (C_ADDR),
        .PTR_RESET   (C_PTR_RESET)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda_line),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .busy      (busy)
    );

    // Local register file behind the window.
    logic [7:0] mem [256];
    logic       mem_init;
    assign reg_rdata = mem[reg_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) + 8'h40;
        end else if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
        end
    end

    // Write-strobe monitor.
    int         obs_n   = 0;
    int         we_long = 0;
    logic       we_prev = 1'b0;
    logic [7:0] obs_addr [512];
    logic [7:0] obs_data [512];

    always @(posedge clk) begin
        we_prev <= reg_we;
        if (reg_we && !reset) begin
            obs_addr[obs_n % 512] <= reg_addr;
            obs_data[obs_n % 512] <= reg_wdata;
            obs_n <= obs_n + 1;
        end
        if (reg_we && we_prev) we_long <= we_long + 1;
    end

    // Reference model: register contents, pointer and expected write list.
    logic [7:0] model_mem [256];
    logic [7:0] model_ptr;
    logic [7:0] exp_addr [512];
    logic [7:0] exp_data [512];
    int         exp_n     = 0;
    int         checked_n = 0;
    logic [7:0] wbuf [8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus master primitives ----------------
    task automatic wait_q();
        repeat (C_Q) @(negedge clk);
    endtask

    // Works both from an idle bus and as a repeated START with SCL low.
    task automatic bus_start();
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda_low = ~b; wait_q();
        scl = 1'b1;     wait_q();
        s = sda_line;   wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    task automatic sync_writes(input string tag);
        check_value({tag, "_wr_count"}, obs_n, exp_n);
        for (int i = checked_n; i < exp_n && i < obs_n; i++) begin
            check_value({tag, "_wr_addr"}, obs_addr[i], exp_addr[i]);
            check_value({tag, "_wr_data"}, obs_data[i], exp_data[i]);
        end
        checked_n = (obs_n < exp_n) ? obs_n : exp_n;
    endtask

    // ---------------- transactions with model prediction ----------------
    task automatic txn_write(input string tag, input logic [7:0] ptr, input int n);
        logic a;
        bus_start();
        write_byte({C_ADDR, 1'b0}, a); check_value({tag, "_addr_ack"}, a, 0);
        write_byte(ptr, a);            check_value({tag, "_ptr_ack"}, a, 0);
        model_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a);    check_value({tag, "_data_ack"}, a, 0);
            exp_addr[exp_n] = model_ptr;
            exp_data[exp_n] = wbuf[i];
            exp_n++;
            model_mem[model_ptr] = wbuf[i];
            model_ptr = model_ptr + 8'd1;
        end
        bus_stop();
        check_value({tag, "_ptr"}, reg_addr, model_ptr);
        sync_writes(tag);
    endtask

    task automatic txn_read(input string tag, input logic set_ptr, input logic [7:0] ptr, input int n);
        logic       a;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            write_byte({C_ADDR, 1'b0}, a); check_value({tag, "_addrw_ack"}, a, 0);
            write_byte(ptr, a);            check_value({tag, "_ptr_ack"}, a, 0);
            model_ptr = ptr;
            bus_start();
        end
        write_byte({C_ADDR, 1'b1}, a);     check_value({tag, "_addrr_ack"}, a, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check_value({tag, "_rdata"}, d, model_mem[model_ptr]);
            if (i != n - 1) model_ptr = model_ptr + 8'd1;
        end
        check_value({tag, "_released_after_nack"}, sda_line, 1);
        bus_stop();
        check_value({tag, "_ptr"}, reg_addr, model_ptr);
        sync_writes(tag);
    endtask

    task automatic txn_bad(input string tag, input logic [6:0] addr, input logic rw);
        logic a;
        bus_start();
        write_byte({addr, rw}, a);
        check_value({tag, "_nack"}, a, 1);
        check_value({tag, "_busy"}, busy, 0);
        bus_stop();
        check_value({tag, "_ptr"}, reg_addr, model_ptr);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic       a;
        logic       s;
        int         lows;
        int         kind;
        logic [6:0] bad;

        reset = 1'b1; scl = 1'b1; m_sda_low = 1'b0; mem_init = 1'b1;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) + 8'h40;
        model_ptr = C_PTR_RESET;
        repeat (5) @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;
        @(negedge clk);

        check_value("rst_reg_addr",  reg_addr,  C_PTR_RESET);
        check_value("rst_reg_we",    reg_we,    0);
        check_value("rst_reg_wdata", reg_wdata, 0);
        check_value("rst_busy",      busy,      0);
        check_value("rst_sda",       sda_line,  1);

        // Address match / mismatch
        bus_start();
        write_byte(8'h90, a);
        check_value("match_ack",  a,    0);
        check_value("match_busy", busy, 1);
        bus_stop();
        check_value("stop_busy",  busy, 0);
        txn_bad("mismatch92", 7'h49, 1'b0);

        // Pointer write, data write, combined read, wrap
        txn_write("ptr_write", 8'h01, 0);
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        txn_write("data_write", 8'h10, 2);
        txn_read("comb_read", 1'b1, 8'h01, 4);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn_write("wrap", 8'hFF, 2);

        // STOP in the middle of a data byte
        bus_start();
        write_byte({C_ADDR, 1'b0}, a);
        write_byte(8'h20, a);
        model_ptr = 8'h20;
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
        bus_stop();
        check_value("midstop_ptr", reg_addr, model_ptr);
        sync_writes("midstop");

        // Reset during the 4th data bit of a read
        bus_start();
        write_byte({C_ADDR, 1'b0}, a);
        write_byte(8'h01, a);
        model_ptr = 8'h01;
        bus_start();
        write_byte({C_ADDR, 1'b1}, a);
        for (int i = 7; i > 4; i--) begin
            bus_bit(1'b1, s);
            check_value("abort_rd_bit", s, model_mem[model_ptr][i]);
        end
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        check_value("abort_bit4_driven", sda_line, model_mem[model_ptr][4]);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check_value("abort_sda_release", sda_line, 1);
        @(negedge clk); reset = 1'b0;
        model_ptr = C_PTR_RESET;
        check_value("abort_ptr",  reg_addr, model_ptr);
        check_value("abort_busy", busy,     0);
        wait_q(); scl = 1'b0; wait_q();
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            bus_bit(1'b1, s);
            if (s == 1'b0) lows++;
        end
        check_value("abort_bus_ignored", lows, 0);
        bus_stop();
        sync_writes("abort");

        // Randomized transactions
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
                    txn_write("rnd_write", ($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom),
                              $urandom_range(0, 4));
                end
                1: txn_read("rnd_comb", 1'b1, 8'($urandom), $urandom_range(1, 4));
                2: txn_read("rnd_cur",  1'b0, 8'h00, $urandom_range(1, 3));
                default: begin
                    do bad = 7'($urandom); while (bad == C_ADDR);
                    txn_bad("rnd_bad", bad, 1'($urandom));
                end
            endcase
        end

        check_value("we_single_clk", we_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
